// File: rtl/bin_to_bcd_pkg.sv
// Constants shared by the binary-to-BCD encoder, the 7-segment decoder and the display mux.
package bin_to_bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Nibble value the 7-segment decoder renders as a blank digit.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_if.sv
// Request/result bundle between a display-path client and the binary-to-BCD encoder.
interface bin_to_bcd_if #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
);
  logic                  start;
  logic [BIN_WIDTH-1:0]  bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin_to_bcd_add3.sv
// Per-digit correction for shift-and-add-3: a digit of 5 or more is bumped by 3 before the shift.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD encoder, one input bit per clock; out-of-range values encode as blank digits.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  bin_to_bcd_if.slave  bus
);

  localparam int          SW      = 4 * DIGITS;
  localparam int          CW      = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] MAX_VAL = 64'(pow10(DIGITS) - 64'd1);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [BIN_WIDTH-1:0]   sreg;
  logic [SW-1:0]          scratch;
  logic [SW-1:0]          corr;
  logic [SW-1:0]          scratch_nxt;
  logic                   ovf_lat;
  logic                   accept;

  function automatic logic [SW-1:0] blank_on_ovf(input logic [SW-1:0] v, input logic ovf);
    return ovf ? {DIGITS{BCD_BLANK}} : v;
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d (scratch[4*g +: 4]),
      .q (corr[4*g +: 4])
    );
  end

  // The bit leaving the top digit is dropped; the latched overflow compare covers it.
  assign scratch_nxt = SW'({corr, sreg[BIN_WIDTH-1]});
  assign accept      = (state == IDLE) && bus.start;

  // Operand / scratch datapath
  always_ff @(posedge i_clk) begin
    if (accept) begin
      sreg    <= bus.bin;
      scratch <= '0;
      ovf_lat <= 64'(bus.bin) > MAX_VAL;
    end else if (state == SHIFT) begin
      sreg    <= {sreg[BIN_WIDTH-2:0], 1'b0};
      scratch <= scratch_nxt;
    end
  end

  // Control FSM and registered results
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.bcd      <= '0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SHIFT;
            cnt      <= CW'(BIN_WIDTH);
            bus.busy <= 1'b1;
          end
        end
        SHIFT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            bus.bcd      <= blank_on_ovf(scratch_nxt, ovf_lat);
            bus.overflow <= ovf_lat;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bin_to_bcd.md
# bin_to_bcd

Sequential binary-to-BCD encoder (shift-and-add-3, one bit per clock) that produces the packed BCD digits consumed by the per-digit 7-segment decoders of the lighting system's display path. It converts an unsigned binary count (brightness level, timer value, mode number) into `DIGITS` decimal digits, least-significant digit in the low nibble. Out-of-range values are flagged and encoded as all-`4'hF` digits, which the 7-segment decoder renders as blank.

## Interface
- `BIN_WIDTH`, 14: width of the unsigned binary input.
- `DIGITS`, 4: number of BCD output digits; `MAX_VAL = 10^DIGITS - 1`.

- `i_clk`  input  1  system clock; all logic on the rising edge.
- `i_rst`  input  1  reset, synchronous, active-high.
- `i_start`  input  1  request a conversion of `i_bin`; sampled only in IDLE.
- `i_bin`  input  BIN_WIDTH  unsigned value; sampled on the accepting edge only.
- `o_busy`  output  1  high while a conversion is in progress.
- `o_done`  output  1  one-cycle pulse; `o_bcd` and `o_overflow` are valid and updated.
- `o_bcd`  output  4*DIGITS  packed BCD result; digit n in bits `[4n+3:4n]`.
- `o_overflow`  output  1  last completed conversion had `i_bin > MAX_VAL`.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: if `i_start`, latch `i_bin` into the shift register, clear the BCD scratch register, load the bit counter with `BIN_WIDTH`, latch the overflow compare (`i_bin > MAX_VAL`), go to SHIFT. Otherwise stay.
- SHIFT, each cycle: for every scratch digit >= 5, add 3; then shift {scratch, shift reg} left one bit; decrement the counter. On the cycle where the counter reaches 0: update `o_bcd` (scratch result, or all `4'hF` if overflow latched), update `o_overflow`, assert `o_done`, go to IDLE.
- `o_bcd` and `o_overflow` hold the last completed result and never change mid-conversion.
- `i_start` during SHIFT is ignored; it is neither queued nor able to alter the latched operand.
- The scratch register is `4*DIGITS` bits. Add-3 is applied per 4-bit nibble with no inter-nibble carry. Bits shifted past the top digit are discarded, and the overflow flag covers that case.
- When `2^BIN_WIDTH - 1 <= MAX_VAL`, the compare is constant 0 and `o_overflow` is never set.

## Timing
- Reset values: state IDLE, `o_busy`=0, `o_done`=0, `o_bcd`=0 (display shows all zeros), `o_overflow`=0, counter 0.
- Start accepted at edge k: `o_busy`=1 from after edge k until edge k+BIN_WIDTH. `o_done`=1 and new `o_bcd` are visible for exactly one cycle after edge k+BIN_WIDTH.
- Latency: BIN_WIDTH cycles from accepting edge to `o_done`. Throughput: one conversion per BIN_WIDTH cycles.
- Back-to-back: `i_start` high in the `o_done` cycle is accepted, because the FSM is in IDLE and `o_busy`=0.
- `o_done` and `o_busy` are never high together.
- Reset mid-conversion: the conversion aborts with no `o_done`. All outputs return to reset values, including `o_bcd`=0.
- Reset and `i_start` in the same cycle: reset wins; no conversion starts.

## Structure
- Shared constants header: FSM state encodings and `BCD_BLANK = 4'hF`. The header is shared with the 7-segment decoder and the display mux.
- One natural sub-module: `bcd_add3`, a combinational nibble correction (`d >= 5 ? d + 3 : d`) instantiated DIGITS times in a generate loop.
- Counter width: `$clog2(BIN_WIDTH+1)`.

## Test plan
- Reset, then `i_bin`=0 with one-cycle `i_start`: `o_busy` high for 14 cycles, then `o_done` pulse with `o_bcd`=16'h0000 and `o_overflow`=0.
- `i_bin`=1234 -> `o_bcd`=16'h1234 after 14 cycles. `i_bin`=9999 -> `o_bcd`=16'h9999 with `o_overflow`=0.
- `i_bin`=10000 -> `o_bcd`=16'hFFFF with `o_overflow`=1. A following `i_bin`=42 -> `o_bcd`=16'h0042 with `o_overflow`=0.
- Convert 5678, then pulse `i_start` with `i_bin`=1111 at cycle 5 of busy -> result stays 16'h5678, exactly one `o_done`, and `o_bcd` is unchanged before `o_done`.
- Back-to-back: assert `i_start` in the `o_done` cycle with `i_bin`=321 -> second `o_done` 14 cycles later with 16'h0321.
- Assert `i_rst` at cycle 7 of a conversion of 8765 -> no `o_done`, `o_busy`=0 and `o_bcd`=0 after the edge. A following conversion of 8765 gives 16'h8765.
